// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  localparam int unsigned MONEY_W = 4;

  localparam logic [MONEY_W-1:0] COIN_1    = MONEY_W'(1);
  localparam logic [MONEY_W-1:0] COIN_2    = MONEY_W'(2);
  localparam logic [MONEY_W-1:0] COIN_5    = MONEY_W'(5);
  localparam logic [MONEY_W-1:0] MONEY_MAX = MONEY_W'(15);

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StVend,
    StChange
  } state_e;

  function automatic logic coin_is_legal(input logic [MONEY_W-1:0] value);
    return (value == COIN_1) || (value == COIN_2) || (value == COIN_5);
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Load/decrement counter paying out change one unit per cycle.
module change_dispenser #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         pulse_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pulse_q, pulse_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
    // Pulse is high on exactly the cycles the visible count is nonzero.
    pulse_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign pulse_o = pulse_q;
  assign done_o  = (cnt_q <= W'(1));

endmodule

// File: rtl/vend_transaction.sv
// Customer-side vending transaction controller: coins, credit, vend, change, bank.
module vend_transaction #(
  parameter int unsigned PRICE_A = 3,
  parameter int unsigned PRICE_B = 5,
  parameter int unsigned MONEY_W = vend_pkg::MONEY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  input  logic               sel,
  input  logic               buy,
  input  logic               cancel,
  input  logic               withdraw,
  output logic [MONEY_W-1:0] credit,
  output logic [MONEY_W-1:0] machine_money,
  output logic               dispense,
  output logic               product_out,
  output logic               change_pulse,
  output logic               coin_reject,
  output logic               red_light
);
  import vend_pkg::*;

  localparam logic [MONEY_W:0] MaxSum = (MONEY_W + 1)'(MONEY_MAX);

  state_e             state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [MONEY_W-1:0] bank_q, bank_d;
  logic               dispense_q, dispense_d;
  logic               product_q, product_d;
  logic               reject_q, reject_d;
  logic               red_q, red_d;

  logic               disp_load, disp_done;
  logic [MONEY_W-1:0] disp_cnt;
  logic [MONEY_W-1:0] price;
  logic [MONEY_W:0]   coin_sum, bank_sum;
  logic               coin_ok;

  assign price    = sel ? MONEY_W'(PRICE_B) : MONEY_W'(PRICE_A);
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
  assign bank_sum = {1'b0, bank_q} + {1'b0, price};
  assign coin_ok  = coin_is_legal(coin_value) && (coin_sum <= MaxSum);

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    bank_d     = bank_q;
    dispense_d = 1'b0;
    product_d  = 1'b0;
    reject_d   = 1'b0;
    red_d      = 1'b0;
    disp_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[MONEY_W-1:0];
            state_d  = StCredit;
          end else begin
            reject_d = 1'b1;
          end
        end
        if (buy) red_d = 1'b1;
        if (withdraw) begin
          if (bank_q != '0) bank_d = '0;
          else              red_d  = 1'b1;
        end
      end
      StCredit: begin
        if (cancel) begin
          state_d   = StChange;
          disp_load = 1'b1;
          credit_d  = '0;
          reject_d  = coin_valid;
        end else if (buy) begin
          reject_d = coin_valid;
          if ((credit_q >= price) && (bank_sum <= MaxSum)) begin
            state_d    = StVend;
            credit_d   = credit_q - price;
            bank_d     = bank_sum[MONEY_W-1:0];
            dispense_d = 1'b1;
            product_d  = sel;
          end else begin
            red_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) credit_d = coin_sum[MONEY_W-1:0];
          else         reject_d = 1'b1;
        end
      end
      StVend: begin
        reject_d = coin_valid;
        // Remaining credit moves into the dispenser, which then owns the count.
        if (credit_q != '0) begin
          state_d   = StChange;
          disp_load = 1'b1;
          credit_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StChange: begin
        reject_d = coin_valid;
        if (disp_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      bank_q     <= '0;
      dispense_q <= 1'b0;
      product_q  <= 1'b0;
      reject_q   <= 1'b0;
      red_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      bank_q     <= bank_d;
      dispense_q <= dispense_d;
      product_q  <= product_d;
      reject_q   <= reject_d;
      red_q      <= red_d;
    end
  end

  change_dispenser #(
    .W(MONEY_W)
  ) u_change (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (disp_load),
    .load_val_i(credit_q),
    .cnt_o     (disp_cnt),
    .pulse_o   (change_pulse),
    .done_o    (disp_done)
  );

  assign credit        = (state_q == StChange) ? disp_cnt : credit_q;
  assign machine_money = bank_q;
  assign dispense      = dispense_q;
  assign product_out   = product_q;
  assign coin_reject   = reject_q;
  assign red_light     = red_q;

endmodule
